// File: rtl/prod_bcd_pkg.sv
// Shared types and constants for the product binary-to-BCD converter.
package prod_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         BCD_SHIFTS = 8;
    localparam logic [3:0] BCD_BLANK  = 4'hF;

endpackage

// File: rtl/prod_bcd_conv_add3.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 before the shift.
module add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, 8 shifts).
// Define PROD_BCD_BLANK_EN to blank leading zero digits with 4'hF.
module prod_bcd_conv
    import prod_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       aclr_n,
    input  logic       done_flag,
    input  logic [7:0] product_in,
    output logic       busy,
    output logic       bcd_valid,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);

    localparam logic [2:0] LAST_CNT = 3'(BCD_SHIFTS - 1);

    state_t      state;
    logic        done_d;
    logic [2:0]  cnt;
    logic [7:0]  bin_sr;
    logic [11:0] bcd_sr;
    logic [11:0] corr;
    logic [19:0] work;
    logic [19:0] shifted;
    logic        req;

    function automatic logic [11:0] format_digits(input logic [11:0] d);
`ifdef PROD_BCD_BLANK_EN
        logic [3:0] h;
        logic [3:0] t;
        h = d[11:8];
        t = d[7:4];
        if (d[11:8] == 4'd0) begin
            h = BCD_BLANK;
            if (d[7:4] == 4'd0)
                t = BCD_BLANK;
        end
        return {h, t, d[3:0]};
`else
        return d;
`endif
    endfunction

    assign req = done_flag & ~done_d;

    add3 u_add3_ones (.digit(bcd_sr[3:0]),  .fixed(corr[3:0]));
    add3 u_add3_tens (.digit(bcd_sr[7:4]),  .fixed(corr[7:4]));
    add3 u_add3_hund (.digit(bcd_sr[11:8]), .fixed(corr[11:8]));

    // Correction first, then one left shift of the combined register.
    assign work    = {corr, bin_sr};
    assign shifted = work << 1;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            cnt       <= 3'd0;
            bin_sr    <= 8'd0;
            bcd_sr    <= 12'd0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
            bcd_hund  <= 4'd0;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
        end else begin
            done_d <= done_flag;
            case (state)
                IDLE: begin
                    if (req) begin
                        bin_sr    <= product_in;
                        bcd_sr    <= 12'd0;
                        cnt       <= 3'd0;
                        busy      <= 1'b1;
                        bcd_valid <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted[19:8];
                    bin_sr <= shifted[7:0];
                    cnt    <= cnt + 3'd1;
                    // Requests arriving here are dropped; done_d keeps tracking.
                    if (cnt == LAST_CNT) begin
                        {bcd_hund, bcd_tens, bcd_ones} <= format_digits(shifted[19:8]);
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Randomized and directed bench for prod_bcd_conv against an arithmetic digit model.
module tb_prod_bcd_conv;

    logic       clk;
    logic       aclr_n;
    logic       done_flag;
    logic [7:0] product_in;
    logic       busy;
    logic       bcd_valid;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    int vectors;
    int miscompares;

    prod_bcd_conv dut (
        .clk        (clk),
        .aclr_n     (aclr_n),
        .done_flag  (done_flag),
        .product_in (product_in),
        .busy       (busy),
        .bcd_valid  (bcd_valid),
        .bcd_hund   (bcd_hund),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] model_digits(input int p);
        int h, t, o;
        h = p / 100;
        t = (p / 10) % 10;
        o = p % 10;
`ifdef PROD_BCD_BLANK_EN
        if (h == 0) begin
            h = 15;
            if (t == 0) t = 15;
        end
`endif
        return {h[3:0], t[3:0], o[3:0]};
    endfunction

    task automatic test_reset();
        aclr_n = 1'b0;
        done_flag = 1'b0;
        product_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, bcd_valid, bcd_hund, bcd_tens, bcd_ones} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", {busy, bcd_valid, bcd_hund, bcd_tens, bcd_ones});
        end
        @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_conversions(input int count, input bit randomize);
        int vals[9] = '{225, 255, 0, 9, 40, 100, 99, 10, 1};
        int p, n;
        logic [11:0] exp_d;
        for (int i = 0; i < count; i++) begin
            p = randomize ? int'($urandom_range(0, 255)) : vals[i];
            exp_d = model_digits(p);
            @(negedge clk);
            product_in = p[7:0];
            done_flag = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL start_flags p=%0d busy=%b valid=%b want busy=1 valid=0", p, busy, bcd_valid);
            end
            n = 0;
            while (bcd_valid !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            vectors++;
            if (n != 8) begin
                miscompares++;
                $display("FAIL latency p=%0d got %0d want 8", p, n);
            end
            vectors++;
            if ({bcd_hund, bcd_tens, bcd_ones} !== exp_d || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL digits p=%0d got %h busy=%b want %h busy=0", p,
                         {bcd_hund, bcd_tens, bcd_ones}, busy, exp_d);
            end
            @(negedge clk);
            done_flag = 1'b0;
        end
    endtask

    task automatic test_ignore_during_shift();
        logic [11:0] exp_d;
        exp_d = model_digits(100);
        @(negedge clk);
        product_in = 8'd100;
        done_flag = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k <= 7) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_hold edge=E+%0d got %b want 1", k, busy);
                end
            end
            @(negedge clk);
            if (k == 1) done_flag = 1'b0;
            if (k == 2) begin
                done_flag = 1'b1;
                product_in = 8'd7;
            end
            if (k == 7) begin
                #4;
            end
        end
        vectors++;
        if (bcd_valid !== 1'b1 || busy !== 1'b0 || {bcd_hund, bcd_tens, bcd_ones} !== exp_d) begin
            miscompares++;
            $display("FAIL ignore_result got v=%b b=%b d=%h want v=1 b=0 d=%h", bcd_valid, busy,
                     {bcd_hund, bcd_tens, bcd_ones}, exp_d);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || bcd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL no_restart busy=%b valid=%b want busy=0 valid=1", busy, bcd_valid);
        end
        @(negedge clk);
        done_flag = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_level();
        int p, starts;
        logic prev_busy;
        logic [11:0] exp_d;
        p = int'($urandom_range(0, 255));
        exp_d = model_digits(p);
        starts = 0;
        prev_busy = 1'b0;
        @(negedge clk);
        product_in = p[7:0];
        done_flag = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b1 && prev_busy !== 1'b1) starts++;
            prev_busy = busy;
        end
        vectors++;
        if (starts != 1) begin
            miscompares++;
            $display("FAIL held_level_starts got %0d want 1", starts);
        end
        vectors++;
        if (bcd_valid !== 1'b1 || {bcd_hund, bcd_tens, bcd_ones} !== exp_d) begin
            miscompares++;
            $display("FAIL held_level_result p=%0d got v=%b d=%h want v=1 d=%h", p, bcd_valid,
                     {bcd_hund, bcd_tens, bcd_ones}, exp_d);
        end
        @(negedge clk);
        done_flag = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_clear();
        int n;
        logic [11:0] exp_d;
        exp_d = model_digits(225);
        @(negedge clk);
        product_in = 8'd225;
        done_flag = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        aclr_n = 1'b0;
        #1;
        vectors++;
        if ({busy, bcd_valid, bcd_hund, bcd_tens, bcd_ones} !== 14'd0) begin
            miscompares++;
            $display("FAIL async_clear got %h want 0", {busy, bcd_valid, bcd_hund, bcd_tens, bcd_ones});
        end
        @(negedge clk);
        aclr_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_after_clear busy=%b want 1", busy);
        end
        n = 0;
        while (bcd_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (n != 8 || {bcd_hund, bcd_tens, bcd_ones} !== exp_d) begin
            miscompares++;
            $display("FAIL clear_reconvert got n=%0d d=%h want n=8 d=%h", n,
                     {bcd_hund, bcd_tens, bcd_ones}, exp_d);
        end
        @(negedge clk);
        done_flag = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_conversions(9, 1'b0);
        test_conversions(25, 1'b1);
        test_ignore_during_shift();
        test_held_level();
        test_async_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
